buff_reg_ctrl: RTL and testbench
================================

// Module: buff_reg_ctrl
// PURPOSE
//  Sequencer for the LVDA set/reset buffer-register latches (BRD1, BRD2, BRD7, BRD8, MODR1, MODR2).
//  Latches are set-only, and clear by group: BRR1 clears BRD1/2/7/8; MODRR clears MODR1/2.
//  Turns a masked word write into clear/settle/set phases with fixed pulse widths.
//  Keeps a shadow copy of the latch state. Sits between process-output command decode and buff_regs_2.
// PARAMETERS
//  CLR_CYC  2  cycles BRR1/MODRR held high per clear phase (>=1)
//  GAP_CYC  1  settle cycles between clear and set (>=1)
//  STB_CYC  1  cycles SET_STB held high per set phase (>=1)
// PORTS
//  SIM_CLK      in   1  system clock, all state on rising edge
//  SIM_RST      in   1  asynchronous reset, active high
//  CMD_VALID    in   1  write request
//  CMD_READY    out  1  request accepted on edge where VALID&READY
//  CMD_MASK     in   6  bit enables; bit map [0]BRD1 [1]BRD2 [2]BRD7 [3]BRD8 [4]MODR1 [5]MODR2
//  CMD_DATA     in   6  target values for masked bits
//  BRR1         out  1  BRD group clear pulse
//  MODRR        out  1  MODR group clear pulse
//  SET_STB      out  6  per-bit set strobes (same bit map), drive latch set terms
//  BUSY         out  1  sequence in progress (state != IDLE)
//  DONE         out  1  one-cycle completion pulse
//  SHADOW       out  6  committed latch image
//  RB           in   6  latch readback, same bit map (used only with BUFF_REG_CTRL_RB_EN)
//  ERR_CLR      in   1  clears RB_ERR
//  RB_ERR       out  1  sticky readback mismatch flag
// BEHAVIOUR
//  Reset (async, any state): state IDLE; SHADOW=0; BRR1=MODRR=0; SET_STB=0; DONE=0; BUSY=0; RB_ERR=0.
//   CMD_READY=1 during and after reset.
//  CMD_READY = (state==IDLE), combinational. A VALID while not ready is held off, never dropped.
//  On accept at edge T, register:
//   NEW   = (SHADOW & ~MASK) | (DATA & MASK)
//   CLR_B = |(SHADOW[3:0] & ~NEW[3:0]);  CLR_M = |(SHADOW[5:4] & ~NEW[5:4])
//   SETV[3:0] = CLR_B ? NEW[3:0] : NEW[3:0] & ~SHADOW[3:0]
//   SETV[5:4] = CLR_M ? NEW[5:4] : NEW[5:4] & ~SHADOW[5:4]
//  States: IDLE -> CLEAR -> GAP -> SET -> DONE -> IDLE.
//  CLEAR: BRR1=CLR_B and MODRR=CLR_M for CLR_CYC cycles starting T+1.
//   Entered only if CLR_B|CLR_M; otherwise CLEAR and GAP are both skipped.
//  GAP: all drive outputs low for GAP_CYC cycles.
//  SET: SET_STB=SETV for STB_CYC cycles. Skipped if SETV==0.
//  DONE: DONE=1 for exactly one cycle; SHADOW<=NEW at the end of this cycle; next state IDLE.
//  Full-path latency from accept to DONE: CLR_CYC+GAP_CYC+STB_CYC+1 cycles.
//   Set-only path: STB_CYC+1. MASK==0 or no change: DONE at T+1, no strobes, SHADOW unchanged.
//  Clear and set never overlap. BRR1/MODRR/SET_STB are registered and glitch-free.
//  Back-to-back: earliest next accept is the cycle after DONE.
//  SIM_RST mid-sequence: outputs drop at once; SHADOW=0 (latches are assumed cleared by system reset).
//  Counters are sized to max(CLR_CYC,GAP_CYC,STB_CYC) and reload on every state entry.
// CONFIGURATION
//  BUFF_REG_CTRL_RB_EN defined:
//   In DONE, if RB != NEW then RB_ERR<=1. RB_ERR stays set until ERR_CLR.
//   If ERR_CLR and a mismatch occur in the same cycle, set wins.
//  BUFF_REG_CTRL_RB_EN undefined:
//   RB and ERR_CLR ignored; RB_ERR tied 0; ports still present.
// TESTING
//  Reset, then MASK=6'h3F DATA=6'h0A:
//   no clear; SET_STB=6'h0A for 1 cycle at T+1; DONE at T+2; SHADOW=6'h0A.
//  From SHADOW=6'h0A, MASK=6'h02 DATA=0:
//   BRR1 high T+1..T+2, MODRR low; gap T+3; SET_STB=6'h08 at T+4; DONE at T+5; SHADOW=6'h08.
//  From SHADOW=6'h38, MASK=6'h30 DATA=6'h10:
//   MODRR only, 2 cycles; SET_STB=6'h10; SHADOW=6'h18.
//  MASK=0, or write of identical data:
//   DONE at T+1, BRR1/MODRR/SET_STB stay 0.
//  VALID held continuously with two commands:
//   READY low T+1..DONE; second accept on the cycle after DONE.
//  SIM_RST asserted during CLEAR:
//   BRR1 drops asynchronously; state IDLE, SHADOW=0.
//  With RB_EN, RB stuck at 0 on write of 6'h01:
//   RB_ERR=1 after DONE, holds until ERR_CLR.

Source files
------------

// File: rtl/buff_reg_ctrl.sv
// Sequencer for the BRD/MODR set/reset buffer latches: masked write -> clear, settle, set, done.
// Latency: accept->DONE is CLR_CYC+GAP_CYC+STB_CYC+1 (full), STB_CYC+1 (set only), 1 (no change).
// Backpressure: CMD_READY only in IDLE; a held VALID waits, is never dropped. Option: BUFF_REG_CTRL_RB_EN.
module buff_reg_ctrl #(
    parameter int CLR_CYC = 2,
    parameter int GAP_CYC = 1,
    parameter int STB_CYC = 1
) (
    input  logic       SIM_CLK,
    input  logic       SIM_RST,
    input  logic       CMD_VALID,
    output logic       CMD_READY,
    input  logic [5:0] CMD_MASK,
    input  logic [5:0] CMD_DATA,
    output logic       BRR1,
    output logic       MODRR,
    output logic [5:0] SET_STB,
    output logic       BUSY,
    output logic       DONE,
    output logic [5:0] SHADOW,
    input  logic [5:0] RB,
    input  logic       ERR_CLR,
    output logic       RB_ERR
);

    localparam int MAX_AB  = (CLR_CYC > GAP_CYC) ? CLR_CYC : GAP_CYC;
    localparam int MAX_CYC = (MAX_AB > STB_CYC) ? MAX_AB : STB_CYC;
    localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_GAP   = 3'd2,
        ST_SET   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;

    logic          accept;
    logic [5:0]    new_c, setv_c;
    logic          clr_b_c, clr_m_c;

    logic [5:0]    new_q, setv_q;
    logic          clr_b_q, clr_m_q;
    logic [5:0]    shadow_q;

    logic          clr_b_n, clr_m_n;
    logic [5:0]    setv_n;
    logic          brr1_d, modrr_d, done_d;
    logic [5:0]    stb_d;
    logic          brr1_q, modrr_q, done_q;
    logic [5:0]    stb_q;

    assign CMD_READY = (state == ST_IDLE);
    assign BUSY      = (state != ST_IDLE);
    assign accept    = CMD_VALID && CMD_READY;
    assign SHADOW    = shadow_q;
    assign BRR1      = brr1_q;
    assign MODRR     = modrr_q;
    assign SET_STB   = stb_q;
    assign DONE      = done_q;

    // Work out the target image and per-group clear/set plan for the offered command.
    // A group that needs any bit cleared is wiped and fully re-set; otherwise only rising bits are set.
    always_comb begin
        new_c   = (shadow_q & ~CMD_MASK) | (CMD_DATA & CMD_MASK);
        clr_b_c = |(shadow_q[3:0] & ~new_c[3:0]);
        clr_m_c = |(shadow_q[5:4] & ~new_c[5:4]);
        setv_c[3:0] = clr_b_c ? new_c[3:0] : (new_c[3:0] & ~shadow_q[3:0]);
        setv_c[5:4] = clr_m_c ? new_c[5:4] : (new_c[5:4] & ~shadow_q[5:4]);
    end

    // Capture the command plan on accept; it stays stable for the whole sequence.
    always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
        if (SIM_RST) begin
            new_q   <= '0;
            setv_q  <= '0;
            clr_b_q <= 1'b0;
            clr_m_q <= 1'b0;
        end else if (accept) begin
            new_q   <= new_c;
            setv_q  <= setv_c;
            clr_b_q <= clr_b_c;
            clr_m_q <= clr_m_c;
        end
    end

    // State and phase counter register.
    always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
        if (SIM_RST) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state: counter reloads with (phase length - 1) on each entry, exits at zero.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = (cnt != '0) ? (cnt - CW'(1)) : cnt;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (clr_b_c || clr_m_c) begin
                        state_nxt = ST_CLEAR;
                        cnt_nxt   = CW'(CLR_CYC - 1);
                    end else if (setv_c != '0) begin
                        state_nxt = ST_SET;
                        cnt_nxt   = CW'(STB_CYC - 1);
                    end else begin
                        state_nxt = ST_DONE;
                        cnt_nxt   = '0;
                    end
                end
            end
            ST_CLEAR: begin
                if (cnt == '0) begin
                    state_nxt = ST_GAP;
                    cnt_nxt   = CW'(GAP_CYC - 1);
                end
            end
            ST_GAP: begin
                if (cnt == '0) begin
                    if (setv_q != '0) begin
                        state_nxt = ST_SET;
                        cnt_nxt   = CW'(STB_CYC - 1);
                    end else begin
                        state_nxt = ST_DONE;
                        cnt_nxt   = '0;
                    end
                end
            end
            ST_SET: begin
                if (cnt == '0) begin
                    state_nxt = ST_DONE;
                    cnt_nxt   = '0;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Drive values decoded from the next state so the output flops line up with the state.
    always_comb begin
        clr_b_n = accept ? clr_b_c : clr_b_q;
        clr_m_n = accept ? clr_m_c : clr_m_q;
        setv_n  = accept ? setv_c  : setv_q;
        brr1_d  = (state_nxt == ST_CLEAR) && clr_b_n;
        modrr_d = (state_nxt == ST_CLEAR) && clr_m_n;
        stb_d   = (state_nxt == ST_SET) ? setv_n : 6'h00;
        done_d  = (state_nxt == ST_DONE);
    end

    // Registered, glitch-free latch drives; reset drops them immediately.
    always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
        if (SIM_RST) begin
            brr1_q  <= 1'b0;
            modrr_q <= 1'b0;
            stb_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            brr1_q  <= brr1_d;
            modrr_q <= modrr_d;
            stb_q   <= stb_d;
            done_q  <= done_d;
        end
    end

    // Shadow image commits at the end of DONE; system reset clears the real latches too.
    always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
        if (SIM_RST) begin
            shadow_q <= '0;
        end else if (state == ST_DONE) begin
            shadow_q <= new_q;
        end
    end

`ifdef BUFF_REG_CTRL_RB_EN
    // Sticky readback check in DONE; a mismatch in the same cycle as ERR_CLR keeps the flag set.
    always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
        if (SIM_RST) begin
            RB_ERR <= 1'b0;
        end else if ((state == ST_DONE) && (RB != new_q)) begin
            RB_ERR <= 1'b1;
        end else if (ERR_CLR) begin
            RB_ERR <= 1'b0;
        end
    end
`else
    logic unused_rb;
    assign unused_rb = ^{RB, ERR_CLR};
    assign RB_ERR    = 1'b0;
`endif

endmodule

// File: tb/tb_buff_reg_ctrl.sv
// Bench for buff_reg_ctrl: directed vector table plus hand sequences.
// Latency: n/a.
// Backpressure: commands wait for CMD_READY at the falling edge before the accepting edge.
module tb_buff_reg_ctrl;

    logic       SIM_CLK;
    logic       SIM_RST;
    logic       CMD_VALID;
    logic       CMD_READY;
    logic [5:0] CMD_MASK;
    logic [5:0] CMD_DATA;
    logic       BRR1;
    logic       MODRR;
    logic [5:0] SET_STB;
    logic       BUSY;
    logic       DONE;
    logic [5:0] SHADOW;
    logic [5:0] RB;
    logic       ERR_CLR;
    logic       RB_ERR;

    int n_pass = 0;
    int n_tot  = 0;

    buff_reg_ctrl dut (
        .SIM_CLK  (SIM_CLK),
        .SIM_RST  (SIM_RST),
        .CMD_VALID(CMD_VALID),
        .CMD_READY(CMD_READY),
        .CMD_MASK (CMD_MASK),
        .CMD_DATA (CMD_DATA),
        .BRR1     (BRR1),
        .MODRR    (MODRR),
        .SET_STB  (SET_STB),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .SHADOW   (SHADOW),
        .RB       (RB),
        .ERR_CLR  (ERR_CLR),
        .RB_ERR   (RB_ERR)
    );

    initial SIM_CLK = 1'b0;
    always #5 SIM_CLK = ~SIM_CLK;

    typedef struct {
        logic [5:0] mask;
        logic [5:0] data;
        int         brr;
        int         mod;
        logic [5:0] stb;
        int         stbc;
        int         stba;
        int         lat;
        logic [5:0] sh;
    } vec_t;

    typedef struct {
        int         rdy1;
        int         brr;
        int         mod;
        logic [5:0] stb;
        int         stbc;
        int         stba;
        int         lat;
        int         ovl;
        int         done_after;
        logic [5:0] sh;
    } meas_t;

    vec_t vt[9];

    task automatic chk(input string nm, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    endtask

    // Offer one command, wait for accept, then observe every cycle up to DONE and one beyond.
    task automatic run_cmd(input logic [5:0] m, input logic [5:0] d, output meas_t r);
        int w;
        r.rdy1 = -1; r.brr = 0; r.mod = 0; r.stb = '0; r.stbc = 0; r.stba = 0;
        r.lat = -1; r.ovl = 0; r.done_after = -1; r.sh = '0;
        @(negedge SIM_CLK);
        CMD_VALID = 1'b1; CMD_MASK = m; CMD_DATA = d;
        w = 0;
        while (!CMD_READY && w < 40) begin
            @(negedge SIM_CLK);
            w++;
        end
        if (!CMD_READY) begin
            CMD_VALID = 1'b0;
            r.lat = -2;
            return;
        end
        @(posedge SIM_CLK); #1;
        CMD_VALID = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (k == 1) r.rdy1 = int'(CMD_READY);
            if (BRR1) r.brr++;
            if (MODRR) r.mod++;
            if (SET_STB != '0) begin
                r.stbc++;
                r.stb |= SET_STB;
                if (r.stba == 0) r.stba = k;
            end
            if ((BRR1 || MODRR) && (SET_STB != '0)) r.ovl++;
            if (DONE) begin
                r.lat = k;
                break;
            end
            @(posedge SIM_CLK); #1;
        end
        @(posedge SIM_CLK); #1;
        r.done_after = int'(DONE);
        r.sh = SHADOW;
    endtask

    initial begin
        meas_t r;
        int    cnt;

        vt[0] = '{6'h3F, 6'h0A, 0, 0, 6'h0A, 1, 1, 2, 6'h0A};
        vt[1] = '{6'h02, 6'h00, 2, 0, 6'h08, 1, 4, 5, 6'h08};
        vt[2] = '{6'h30, 6'h30, 0, 0, 6'h30, 1, 1, 2, 6'h38};
        vt[3] = '{6'h30, 6'h10, 0, 2, 6'h10, 1, 4, 5, 6'h18};
        vt[4] = '{6'h00, 6'h3F, 0, 0, 6'h00, 0, 0, 1, 6'h18};
        vt[5] = '{6'h3F, 6'h18, 0, 0, 6'h00, 0, 0, 1, 6'h18};
        vt[6] = '{6'h3F, 6'h00, 2, 2, 6'h00, 0, 0, 4, 6'h00};
        vt[7] = '{6'h0F, 6'h05, 0, 0, 6'h05, 1, 1, 2, 6'h05};
        vt[8] = '{6'h21, 6'h20, 2, 0, 6'h24, 1, 4, 5, 6'h24};

        SIM_RST = 1'b1; CMD_VALID = 1'b0; CMD_MASK = '0; CMD_DATA = '0;
        RB = '0; ERR_CLR = 1'b0;

        // Reset state
        #2;
        chk("rst_ready",  int'(CMD_READY), 1);
        chk("rst_busy",   int'(BUSY),      0);
        chk("rst_shadow", int'(SHADOW),    0);
        chk("rst_brr1",   int'(BRR1),      0);
        chk("rst_modrr",  int'(MODRR),     0);
        chk("rst_stb",    int'(SET_STB),   0);
        chk("rst_done",   int'(DONE),      0);
        chk("rst_rberr",  int'(RB_ERR),    0);
        @(negedge SIM_CLK);
        @(negedge SIM_CLK);
        SIM_RST = 1'b0;

        // Vector table
        for (int i = 0; i < 9; i++) begin
            RB = vt[i].sh;
            run_cmd(vt[i].mask, vt[i].data, r);
            chk($sformatf("v%0d_ready_low", i), r.rdy1, 0);
            chk($sformatf("v%0d_brr1_cyc", i), r.brr, vt[i].brr);
            chk($sformatf("v%0d_modrr_cyc", i), r.mod, vt[i].mod);
            chk($sformatf("v%0d_stb_val", i), int'(r.stb), int'(vt[i].stb));
            chk($sformatf("v%0d_stb_cyc", i), r.stbc, vt[i].stbc);
            chk($sformatf("v%0d_stb_at", i), r.stba, vt[i].stba);
            chk($sformatf("v%0d_latency", i), r.lat, vt[i].lat);
            chk($sformatf("v%0d_overlap", i), r.ovl, 0);
            chk($sformatf("v%0d_done_1cyc", i), r.done_after, 0);
            chk($sformatf("v%0d_shadow", i), int'(r.sh), int'(vt[i].sh));
        end

        // Readback: latches stuck at 0 while writing 6'h01
        RB = 6'h00;
        run_cmd(6'h3F, 6'h01, r);
        chk("rb_shadow", int'(r.sh), 6'h01);
`ifdef BUFF_REG_CTRL_RB_EN
        chk("rb_err_set", int'(RB_ERR), 1);
        repeat (3) @(posedge SIM_CLK);
        #1;
        chk("rb_err_hold", int'(RB_ERR), 1);
        @(negedge SIM_CLK); ERR_CLR = 1'b1;
        @(posedge SIM_CLK); #1; ERR_CLR = 1'b0;
        chk("rb_err_clr", int'(RB_ERR), 0);
`else
        chk("rb_err_tied", int'(RB_ERR), 0);
        @(negedge SIM_CLK); ERR_CLR = 1'b1;
        @(posedge SIM_CLK); #1; ERR_CLR = 1'b0;
        chk("rb_err_tied2", int'(RB_ERR), 0);
`endif

        // Back-to-back with VALID held: A = set bit1 (03), B = clear all (00)
        RB = 6'h03;
        @(negedge SIM_CLK);
        CMD_VALID = 1'b1; CMD_MASK = 6'h3F; CMD_DATA = 6'h03;
        chk("b2b_ready_a", int'(CMD_READY), 1);
        @(posedge SIM_CLK); #1;
        CMD_DATA = 6'h00;
        chk("b2b_busy_t1", int'(CMD_READY), 0);
        cnt = 0;
        while (!DONE && cnt < 40) begin
            @(posedge SIM_CLK); #1;
            cnt++;
        end
        chk("b2b_lat_a", cnt + 1, 2);
        chk("b2b_ready_in_done", int'(CMD_READY), 0);
        @(posedge SIM_CLK); #1;
        chk("b2b_ready_after", int'(CMD_READY), 1);
        chk("b2b_shadow_a", int'(SHADOW), 6'h03);
        @(posedge SIM_CLK); #1;
        chk("b2b_accept_b", int'(BUSY), 1);
        CMD_VALID = 1'b0;
        RB = 6'h00;
        cnt = 0;
        while (!DONE && cnt < 40) begin
            @(posedge SIM_CLK); #1;
            cnt++;
        end
        chk("b2b_lat_b", cnt + 1, 4);
        @(posedge SIM_CLK); #1;
        chk("b2b_shadow_b", int'(SHADOW), 6'h00);

        // Reset during CLEAR
        RB = 6'h01;
        run_cmd(6'h01, 6'h01, r);
        chk("mr_pre_shadow", int'(r.sh), 6'h01);
        @(negedge SIM_CLK);
        CMD_VALID = 1'b1; CMD_MASK = 6'h01; CMD_DATA = 6'h00;
        @(posedge SIM_CLK); #1;
        CMD_VALID = 1'b0;
        chk("mr_brr1_on", int'(BRR1), 1);
        #2 SIM_RST = 1'b1;
        #1;
        chk("mr_brr1_drop", int'(BRR1), 0);
        chk("mr_busy", int'(BUSY), 0);
        chk("mr_ready", int'(CMD_READY), 1);
        chk("mr_shadow", int'(SHADOW), 0);
        @(negedge SIM_CLK);
        SIM_RST = 1'b0;

        // Recovery after reset
        RB = 6'h0A;
        run_cmd(6'h3F, 6'h0A, r);
        chk("post_rst_lat", r.lat, 2);
        chk("post_rst_shadow", int'(r.sh), 6'h0A);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
